mem_arbiter: RTL and testbench

Two-requester, round-robin arbiter sharing one `mem` instance between instruction fetch and data load/store. It lets the core run from a single unified memory instead of separate rom/ram instances. Each accepted access completes through a registered response one cycle later. The arbiter sits between the fetch/LSU logic of the multi-cycle core and the `mem` port (combinational read, write on clock edge).

---
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter sharing one memory port between fetch and data.
// Each accepted access is answered by a registered response one cycle later.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        last;          // 0 = I granted last, 1 = D granted last
    logic [31:0] resp_data;
    logic        grant_i;
    logic        grant_d;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!reset) begin
            if (i_req && d_req) begin
                grant_i = last;
                grant_d = !last;
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            resp_data <= '0;
        end else begin
            state <= next_state;
            if (grant_i) begin
                last      <= 1'b0;
                resp_data <= mem_rdata;
            end else if (grant_d) begin
                last      <= 1'b1;
                resp_data <= d_wen ? 32'd0 : mem_rdata;
            end
        end
    end

    // Next state depends only on this cycle's grant, giving one access per cycle.
    always_comb begin
        next_state = IDLE;
        if (grant_i) begin
            next_state = RESP_I;
        end else if (grant_d) begin
            next_state = RESP_D;
        end
    end

    always_comb begin
        i_ready   = grant_i;
        d_ready   = grant_d;
        i_rvalid  = (state == RESP_I);
        d_rvalid  = (state == RESP_D);
        i_rdata   = (state == RESP_I) ? resp_data : 32'd0;
        d_rdata   = (state == RESP_D) ? resp_data : 32'd0;
        mem_wen   = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        if (grant_i) begin
            mem_addr = i_addr;
        end else if (grant_d) begin
            mem_wen   = d_wen;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_wen ? d_wstrb : 4'd0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a word memory model on the mem port,
// a cycle-by-cycle vector table, and hand-written contention/reset sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ready  (i_ready),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_wen    (d_wen),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_ready  (d_ready),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    // Memory model: combinational read, byte-strobed write on the clock edge, plus a preload path.
    logic [31:0] mem [0:63];
    logic        pre_en = 1'b0;
    logic [31:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr[7:2]] <= pre_data;
        end else if (mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dwstrb;
        logic        e_iready;
        logic        e_dready;
        logic        e_memwen;
        logic [31:0] e_memaddr;
        logic [31:0] e_memwdata;
        logic [3:0]  e_memwstrb;
        logic        e_irvalid;
        logic [31:0] e_irdata;
        logic        e_drvalid;
        logic [31:0] e_drdata;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    task automatic drive_idle();
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_wen   = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_wstrb = '0;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic apply(input int n, input vec_t v);
        string tag;
        @(negedge clk);
        reset   = v.rst;
        i_req   = v.ireq;
        i_addr  = v.iaddr;
        d_req   = v.dreq;
        d_wen   = v.dwen;
        d_addr  = v.daddr;
        d_wdata = v.dwdata;
        d_wstrb = v.dwstrb;
        #2;
        tag = $sformatf("v%0d", n);
        check({tag, ".i_ready"},   {31'd0, i_ready},  {31'd0, v.e_iready});
        check({tag, ".d_ready"},   {31'd0, d_ready},  {31'd0, v.e_dready});
        check({tag, ".mem_wen"},   {31'd0, mem_wen},  {31'd0, v.e_memwen});
        check({tag, ".mem_addr"},  mem_addr,          v.e_memaddr);
        check({tag, ".mem_wdata"}, mem_wdata,         v.e_memwdata);
        check({tag, ".mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, v.e_memwstrb});
        check({tag, ".i_rvalid"},  {31'd0, i_rvalid}, {31'd0, v.e_irvalid});
        check({tag, ".i_rdata"},   i_rdata,           v.e_irdata);
        check({tag, ".d_rvalid"},  {31'd0, d_rvalid}, {31'd0, v.e_drvalid});
        check({tag, ".d_rdata"},   d_rdata,           v.e_drdata);
    endtask

    initial begin
        logic exp_i;
        logic prev_i;

        reset = 1'b1;
        drive_idle();
        preload(32'h00, 32'h11111111);
        preload(32'h04, 32'h22222222);
        preload(32'h08, 32'h33333333);
        preload(32'h10, 32'h00500093);
        preload(32'h40, 32'h00000000);
        preload(32'h44, 32'hCAFEF00D);

        // Each row is one cycle; rvalid/rdata expectations answer the previous row's grant.
        vecs[0]  = '{1, 1, 32'h10, 1, 1, 32'h44, 32'h12345678, 4'hF,  0, 0, 0, 32'h0,  32'h0,        4'h0,  0, 32'h0,        0, 32'h0};
        vecs[1]  = '{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        4'h0,  0, 0, 0, 32'h0,  32'h0,        4'h0,  0, 32'h0,        0, 32'h0};
        vecs[2]  = '{0, 1, 32'h10, 0, 0, 32'h0,  32'h0,        4'h0,  1, 0, 0, 32'h10, 32'h0,        4'h0,  0, 32'h0,        0, 32'h0};
        vecs[3]  = '{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        4'h0,  0, 0, 0, 32'h0,  32'h0,        4'h0,  1, 32'h00500093, 0, 32'h0};
        vecs[4]  = '{0, 0, 32'h0,  1, 1, 32'h40, 32'hDEADBEEF, 4'hF,  0, 1, 1, 32'h40, 32'hDEADBEEF, 4'hF,  0, 32'h0,        0, 32'h0};
        vecs[5]  = '{0, 0, 32'h0,  1, 0, 32'h40, 32'h0,        4'hF,  0, 1, 0, 32'h40, 32'h0,        4'h0,  0, 32'h0,        1, 32'h0};
        vecs[6]  = '{0, 0, 32'h0,  1, 1, 32'h40, 32'hAA,       4'h1,  0, 1, 1, 32'h40, 32'hAA,       4'h1,  0, 32'h0,        1, 32'hDEADBEEF};
        vecs[7]  = '{0, 0, 32'h0,  1, 0, 32'h40, 32'h0,        4'hF,  0, 1, 0, 32'h40, 32'h0,        4'h0,  0, 32'h0,        1, 32'h0};
        vecs[8]  = '{0, 0, 32'h0,  1, 0, 32'h44, 32'h0,        4'h0,  0, 1, 0, 32'h44, 32'h0,        4'h0,  0, 32'h0,        1, 32'hDEADBEAA};
        vecs[9]  = '{0, 1, 32'h0,  0, 0, 32'h0,  32'h0,        4'h0,  1, 0, 0, 32'h0,  32'h0,        4'h0,  0, 32'h0,        1, 32'hCAFEF00D};
        vecs[10] = '{0, 1, 32'h4,  0, 0, 32'h0,  32'h0,        4'h0,  1, 0, 0, 32'h4,  32'h0,        4'h0,  1, 32'h11111111, 0, 32'h0};
        vecs[11] = '{0, 1, 32'h8,  0, 0, 32'h0,  32'h0,        4'h0,  1, 0, 0, 32'h8,  32'h0,        4'h0,  1, 32'h22222222, 0, 32'h0};
        vecs[12] = '{0, 1, 32'h10, 1, 0, 32'h0,  32'h0,        4'h0,  0, 1, 0, 32'h0,  32'h0,        4'h0,  1, 32'h33333333, 0, 32'h0};
        vecs[13] = '{0, 1, 32'h10, 1, 0, 32'h4,  32'h0,        4'h0,  1, 0, 0, 32'h10, 32'h0,        4'h0,  0, 32'h0,        1, 32'h11111111};
        vecs[14] = '{0, 0, 32'h0,  1, 0, 32'h4,  32'h0,        4'h0,  0, 1, 0, 32'h4,  32'h0,        4'h0,  1, 32'h00500093, 0, 32'h0};
        vecs[15] = '{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        4'h0,  0, 0, 0, 32'h0,  32'h0,        4'h0,  0, 32'h0,        1, 32'h22222222};
        vecs[16] = '{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        4'h0,  0, 0, 0, 32'h0,  32'h0,        4'h0,  0, 32'h0,        0, 32'h0};

        for (int n = 0; n < 17; n++) apply(n, vecs[n]);

        // Contention right after reset: grants alternate I, D, I, D, I, D.
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        prev_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            reset  = 1'b0;
            i_req  = 1'b1;
            i_addr = 32'h10;
            d_req  = 1'b1;
            d_wen  = 1'b0;
            d_addr = 32'h8;
            #2;
            exp_i = (k % 2 == 0);
            check($sformatf("cont%0d.i_ready", k), {31'd0, i_ready}, {31'd0, exp_i});
            check($sformatf("cont%0d.d_ready", k), {31'd0, d_ready}, {31'd0, !exp_i});
            check($sformatf("cont%0d.both_rvalid", k), {31'd0, i_rvalid & d_rvalid}, 32'd0);
            if (k > 0) begin
                check($sformatf("cont%0d.i_rvalid", k), {31'd0, i_rvalid}, {31'd0, prev_i});
                check($sformatf("cont%0d.d_rvalid", k), {31'd0, d_rvalid}, {31'd0, !prev_i});
                check($sformatf("cont%0d.rdata", k), prev_i ? i_rdata : d_rdata,
                      prev_i ? 32'h00500093 : 32'h33333333);
            end
            prev_i = exp_i;
        end
        @(negedge clk);
        drive_idle();
        #2;
        check("cont_tail.d_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("cont_tail.d_rdata", d_rdata, 32'h33333333);

        // Reset while a fetch response is pending.
        @(negedge clk);
        i_req  = 1'b1;
        i_addr = 32'h10;
        #2;
        check("rst_mid.accept", {31'd0, i_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        i_req = 1'b0;
        d_req = 1'b1;
        d_wen = 1'b1;
        d_addr = 32'h4;
        d_wdata = 32'hBADBAD00;
        d_wstrb = 4'hF;
        #2;
        check("rst_mid.d_ready_suppressed", {31'd0, d_ready}, 32'd0);
        check("rst_mid.mem_wen_suppressed", {31'd0, mem_wen}, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        i_req   = 1'b1;
        i_addr  = 32'h10;
        d_req   = 1'b1;
        d_wen   = 1'b0;
        d_addr  = 32'h4;
        d_wdata = 32'h0;
        d_wstrb = 4'h0;
        #2;
        check("rst_mid.i_rvalid", {31'd0, i_rvalid}, 32'd0);
        check("rst_mid.i_rdata", i_rdata, 32'd0);
        check("rst_mid.first_grant_i", {31'd0, i_ready}, 32'd1);
        check("rst_mid.first_grant_d", {31'd0, d_ready}, 32'd0);
        @(negedge clk);
        i_req = 1'b0;
        #2;
        check("rst_mid.next_grant_d", {31'd0, d_ready}, 32'd1);
        check("rst_mid.fetch_resp", i_rdata, 32'h00500093);
        @(negedge clk);
        drive_idle();
        #2;
        check("rst_mid.store_not_written", d_rdata, 32'h22222222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
